// File: rtl/universal_ff_bank_pkg.sv
// Shared definitions for the universal flip-flop bank: mode encodings and
// the per-bit request bundle handed to each cell.
package universal_ff_bank_pkg;

  typedef enum logic [1:0] {
    MODE_SR = 2'b00,
    MODE_JK = 2'b01,
    MODE_D  = 2'b10,
    MODE_T  = 2'b11
  } ff_mode_e;

  typedef struct packed {
    logic     en;
    ff_mode_e mode;
    logic     a;
    logic     b;
    logic     q;
  } cell_req_t;

  typedef struct packed {
    logic q_nxt;
    logic inv_evt;
  } cell_rsp_t;

endpackage

// File: rtl/universal_ff_cell.sv
// One bit of the bank: next-state selection across SR/JK/D/T and SR
// invalid-event detection. Purely combinational; the flop lives in the top.
module universal_ff_cell
  import universal_ff_bank_pkg::*;
(
  input  cell_req_t req,
  output cell_rsp_t rsp
);

  always_comb begin
    rsp.q_nxt   = req.q;
    rsp.inv_evt = 1'b0;
    if (req.en) begin
      unique case (req.mode)
        MODE_SR: begin
          // S=R=1 holds the bit and reports the illegal combination.
          unique case ({req.a, req.b})
            2'b10:   rsp.q_nxt = 1'b1;
            2'b01:   rsp.q_nxt = 1'b0;
            2'b11:   rsp.inv_evt = 1'b1;
            default: rsp.q_nxt = req.q;
          endcase
        end
        MODE_JK: begin
          unique case ({req.a, req.b})
            2'b10:   rsp.q_nxt = 1'b1;
            2'b01:   rsp.q_nxt = 1'b0;
            2'b11:   rsp.q_nxt = ~req.q;
            default: rsp.q_nxt = req.q;
          endcase
        end
        MODE_D:  rsp.q_nxt = req.a;
        MODE_T:  rsp.q_nxt = req.q ^ req.a;
        default: rsp.q_nxt = req.q;
      endcase
    end
  end

endmodule

// File: rtl/universal_ff_bank.sv
// Bank of WIDTH mode-selectable flip-flops with sticky per-bit SR invalid
// flags and a saturating count of cycles that saw any invalid bit.
module universal_ff_bank
  import universal_ff_bank_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] invalid_flag,
  output logic [CNT_W-1:0] invalid_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] flag_q, flag_d;
  logic [WIDTH-1:0] inv_evt;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    cell_req_t req;
    cell_rsp_t rsp;

    assign req = '{en: en, mode: ff_mode_e'(mode), a: a[i], b: b[i], q: q_q[i]};

    universal_ff_cell u_cell (
      .req (req),
      .rsp (rsp)
    );

    assign q_d[i]     = rsp.q_nxt;
    assign inv_evt[i] = rsp.inv_evt;
  end

  always_comb begin
    // A fresh event on a bit overrides a clear landing in the same cycle.
    flag_d = inv_evt | (clr_err ? '0 : flag_q);
    cnt_d  = cnt_q;
    if (|inv_evt && cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= '0;
      flag_q <= '0;
      cnt_q  <= '0;
    end else begin
      q_q    <= q_d;
      flag_q <= flag_d;
      cnt_q  <= cnt_d;
    end
  end

  assign q             = q_q;
  assign qbar          = ~q_q;
  assign invalid_flag  = flag_q;
  assign invalid_count = cnt_q;

endmodule

// File: tb/tb_universal_ff_bank.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a monitor
// pops one per clock edge and compares against the selected instance.
module tb_universal_ff_bank;
  import universal_ff_bank_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0, en = 1'b0, clr_err = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] a = '0, b = '0;

  logic [3:0] q1, qb1, f1;
  logic [7:0] c1;
  logic [3:0] q2, qb2, f2;
  logic [1:0] c2;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit         which;
    logic [3:0] q;
    logic [3:0] flag;
    logic [7:0] cnt;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  bit   stim_done = 1'b0;

  always #5 clk = ~clk;

  universal_ff_bank #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .clr_err(clr_err),
    .q(q1), .qbar(qb1), .invalid_flag(f1), .invalid_count(c1)
  );

  universal_ff_bank #(.WIDTH(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .clr_err(clr_err),
    .q(q2), .qbar(qb2), .invalid_flag(f2), .invalid_count(c2)
  );

  task automatic cmp(input string name, input string fld, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s.%s got=%b want=%b", name, fld, act, req);
    end
  endtask

  // Inputs change on the falling edge; the expectation covers the next rising edge.
  task automatic step(input logic r, input logic e, input logic [1:0] m,
                      input logic [3:0] av, input logic [3:0] bv, input logic c,
                      input bit which, input logic [3:0] eq, input logic [3:0] ef,
                      input logic [7:0] ec, input string name);
    @(negedge clk);
    rst = r; en = e; mode = m; a = av; b = bv; clr_err = c;
    exp_q.push_back('{which: which, q: eq, flag: ef, cnt: ec, name: name});
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        x = exp_q.pop_front();
        if (!x.which) begin
          cmp(x.name, "q",    {4'h0, q1},  {4'h0, x.q});
          cmp(x.name, "qbar", {4'h0, qb1}, {4'h0, ~x.q});
          cmp(x.name, "flag", {4'h0, f1},  {4'h0, x.flag});
          cmp(x.name, "cnt",  c1,          x.cnt);
        end else begin
          cmp(x.name, "q",    {4'h0, q2},  {4'h0, x.q});
          cmp(x.name, "qbar", {4'h0, qb2}, {4'h0, ~x.q});
          cmp(x.name, "flag", {4'h0, f2},  {4'h0, x.flag});
          cmp(x.name, "cnt",  {6'h0, c2},  x.cnt);
        end
      end
    end
  end

  initial begin : stim
    //   rst en mode     a        b        clr  dut q        flag     cnt
    step(1, 0, MODE_SR, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 8'd0, "rst0");
    step(1, 1, MODE_D,  4'b1111, 4'b0000, 0, 0, 4'b0000, 4'b0000, 8'd0, "rst1");
    step(0, 1, MODE_SR, 4'b0101, 4'b0000, 0, 0, 4'b0101, 4'b0000, 8'd0, "sr_set");
    step(0, 1, MODE_SR, 4'b0000, 4'b0100, 0, 0, 4'b0001, 4'b0000, 8'd0, "sr_clr");
    // bit1 has S=R=1: it holds at 0 and raises its flag
    step(0, 1, MODE_SR, 4'b0011, 4'b0010, 0, 0, 4'b0001, 4'b0010, 8'd1, "sr_inv");
    step(0, 1, MODE_SR, 4'b0000, 4'b0000, 1, 0, 4'b0001, 4'b0000, 8'd1, "clr_err");
    step(0, 1, MODE_SR, 4'b1000, 4'b1000, 1, 0, 4'b0001, 4'b1000, 8'd2, "clr_vs_evt");
    step(0, 0, MODE_SR, 4'b1111, 4'b1111, 0, 0, 4'b0001, 4'b1000, 8'd2, "en0_no_evt");
    step(0, 0, MODE_SR, 4'b0000, 4'b0000, 1, 0, 4'b0001, 4'b0000, 8'd2, "en0_clr");
    step(0, 1, MODE_JK, 4'b1111, 4'b1111, 0, 0, 4'b1110, 4'b0000, 8'd2, "jk_tog1");
    step(0, 1, MODE_JK, 4'b1111, 4'b1111, 0, 0, 4'b0001, 4'b0000, 8'd2, "jk_tog2");
    step(0, 0, MODE_JK, 4'b1111, 4'b0000, 0, 0, 4'b0001, 4'b0000, 8'd2, "jk_en0");
    step(0, 1, MODE_JK, 4'b1000, 4'b0001, 0, 0, 4'b1000, 4'b0000, 8'd2, "jk_setclr");
    step(0, 1, MODE_D,  4'b1010, 4'b1111, 0, 0, 4'b1010, 4'b0000, 8'd2, "d_load");
    step(0, 1, MODE_T,  4'b0011, 4'b0000, 0, 0, 4'b1001, 4'b0000, 8'd2, "t_tog");
    step(0, 1, MODE_T,  4'b0000, 4'b1111, 0, 0, 4'b1001, 4'b0000, 8'd2, "t_hold");
    step(0, 1, MODE_SR, 4'b0000, 4'b0000, 0, 0, 4'b1001, 4'b0000, 8'd2, "mode_chg");
    step(0, 1, MODE_SR, 4'b0100, 4'b0100, 0, 0, 4'b1001, 4'b0100, 8'd3, "pre_rst");
    step(1, 1, MODE_SR, 4'b1111, 4'b1111, 0, 0, 4'b0000, 4'b0000, 8'd0, "rst_prio");
    step(0, 1, MODE_D,  4'b0110, 4'b0000, 0, 0, 4'b0110, 4'b0000, 8'd0, "resume");

    // Saturating counter instance (CNT_W=2)
    step(1, 0, MODE_SR, 4'b0000, 4'b0000, 0, 1, 4'b0000, 4'b0000, 8'd0, "sat_rst");
    step(0, 1, MODE_SR, 4'b0001, 4'b0001, 0, 1, 4'b0000, 4'b0001, 8'd1, "sat_1");
    step(0, 1, MODE_SR, 4'b0011, 4'b0011, 0, 1, 4'b0000, 4'b0011, 8'd2, "sat_2");
    step(0, 1, MODE_SR, 4'b0001, 4'b0001, 0, 1, 4'b0000, 4'b0011, 8'd3, "sat_3");
    step(0, 1, MODE_SR, 4'b0001, 4'b0001, 0, 1, 4'b0000, 4'b0011, 8'd3, "sat_4");
    step(0, 1, MODE_SR, 4'b0001, 4'b0001, 1, 1, 4'b0000, 4'b0001, 8'd3, "sat_5");
    step(1, 1, MODE_SR, 4'b0001, 4'b0001, 0, 1, 4'b0000, 4'b0000, 8'd0, "sat_rst_mid");
    step(0, 1, MODE_SR, 4'b0010, 4'b0010, 0, 1, 4'b0000, 4'b0010, 8'd1, "sat_resume");
    stim_done = 1'b1;
  end

  initial begin : finisher
    int budget;
    wait (stim_done);
    budget = 0;
    while (exp_q.size() != 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog timeout reached");
    $fatal(1, "timeout");
  end

endmodule
